// File: rtl/fp_addsub_pipe_if.sv
// Operand/result stream bundle for fp_addsub_pipe: valid/ready on both sides.
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_inexact;

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, flag_invalid, flag_overflow, flag_inexact
  );

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, flag_invalid, flag_overflow, flag_inexact
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract (align, add+normalise, round+pack) with RNE,
// subnormals, exception flags and a ripple-ready stream handshake.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input logic           clk,
  input logic           rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int unsigned EW1 = EXP_W + 1;
  localparam int unsigned RW  = MAN_W + 2;
  localparam int unsigned LzW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3 = ~v3_q | bus.out_ready;
  assign adv2 = ~v2_q | adv3;
  assign adv1 = ~v1_q | adv2;
  assign bus.in_ready = adv1;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic [EXP_W-1:0] ea, eb, el, es, eel, ees, diff, dsat;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic             sa, sb, swap, nan_a, nan_b, inf_a, inf_b, snan_a, snan_b;
  logic [MAN_W+2:0] xs, lost;
  logic [MW-1:0]    ml, ms;
  logic             spec, spec_inv;
  logic [W-1:0]     spec_res;

  always_comb begin
    sa     = bus.a[W-1];
    sb     = bus.b[W-1] ^ bus.op_sub;
    ea     = bus.a[W-2:MAN_W];
    eb     = bus.b[W-2:MAN_W];
    fa     = bus.a[MAN_W-1:0];
    fb     = bus.b[MAN_W-1:0];
    nan_a  = (ea == EXP_ONES) && (fa != '0);
    nan_b  = (eb == EXP_ONES) && (fb != '0);
    inf_a  = (ea == EXP_ONES) && (fa == '0);
    inf_b  = (eb == EXP_ONES) && (fb == '0);
    snan_a = nan_a & ~fa[MAN_W-1];
    snan_b = nan_b & ~fb[MAN_W-1];

    swap = {eb, fb} > {ea, fa};
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    fl   = swap ? fb : fa;
    fs   = swap ? fa : fb;
    eel  = (el == '0) ? EXP_W'(1) : el;
    ees  = (es == '0) ? EXP_W'(1) : es;
    diff = eel - ees;
    dsat = (diff > SHIFT_SAT) ? SHIFT_SAT : diff;
    ml   = {|el, fl, 3'b000};
    xs   = {|es, fs, 2'b00};
    lost = xs & ~({(MAN_W+3){1'b1}} << dsat);
    ms   = {xs >> dsat, |lost};

    spec     = nan_a | nan_b | inf_a | inf_b;
    spec_inv = snan_a | snan_b;
    spec_res = QNAN;
    if (!(nan_a || nan_b)) begin
      if (inf_a && inf_b) begin
        if (sa != sb) spec_inv = 1'b1;
        else          spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (inf_a) begin
        spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (inf_b) begin
        spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
      end
    end
  end

  logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MW-1:0]    s1_ml_q, s1_ms_q;
  logic [W-1:0]     s1_spec_res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_spec_q <= 1'b0; s1_inv_q <= 1'b0;
      s1_exp_q <= '0; s1_ml_q <= '0; s1_ms_q <= '0; s1_spec_res_q <= '0;
    end else if (adv1) begin
      v1_q          <= bus.in_valid;
      s1_sign_q     <= swap ? sb : sa;
      s1_sub_q      <= sa ^ sb;
      s1_spec_q     <= spec;
      s1_inv_q      <= spec_inv;
      s1_exp_q      <= eel;
      s1_ml_q       <= ml;
      s1_ms_q       <= ms;
      s1_spec_res_q <= spec_res;
    end
  end

  // ---------------- S2: add/sub and normalise ----------------
  logic [MW:0]    sum;
  logic [LzW-1:0] lzc;
  logic [EW1-1:0] lzc_ext, lim, sh, e2;
  logic [MW-1:0]  m2;
  logic           sign2;

  always_comb begin
    sum = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q}) : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
    lzc = LzW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (sum[i]) lzc = LzW'(MW - 1 - i);
    end
    lzc_ext = EW1'(lzc);
    lim     = {1'b0, s1_exp_q} - EW1'(1);
    sh      = (lzc_ext < lim) ? lzc_ext : lim;
    if (sum[MW]) begin
      m2 = {sum[MW:2], sum[1] | sum[0]};
      e2 = {1'b0, s1_exp_q} + EW1'(1);
    end else begin
      m2 = sum[MW-1:0] << sh;
      // Leading bit still clear after the clamped shift means a subnormal result.
      e2 = m2[MW-1] ? ({1'b0, s1_exp_q} - sh) : '0;
    end
    sign2 = (sum == '0 && s1_sub_q) ? 1'b0 : s1_sign_q;
  end

  logic           s2_sign_q, s2_spec_q, s2_inv_q;
  logic [EW1-1:0] s2_exp_q;
  logic [MW-1:0]  s2_man_q;
  logic [W-1:0]   s2_spec_res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0; s2_sign_q <= 1'b0; s2_spec_q <= 1'b0; s2_inv_q <= 1'b0;
      s2_exp_q <= '0; s2_man_q <= '0; s2_spec_res_q <= '0;
    end else if (adv2) begin
      v2_q          <= v1_q;
      s2_sign_q     <= sign2;
      s2_spec_q     <= s1_spec_q;
      s2_inv_q      <= s1_inv_q;
      s2_exp_q      <= e2;
      s2_man_q      <= m2;
      s2_spec_res_q <= s1_spec_res_q;
    end
  end

  // ---------------- S3: round to nearest even and pack ----------------
  logic           rnd_up;
  logic [RW-1:0]  rnd;
  logic [EW1-1:0] e3;
  logic [W-1:0]   res3;
  logic           inv3, ovf3, inx3;

  always_comb begin
    rnd_up = s2_man_q[2] & (s2_man_q[1] | s2_man_q[0] | s2_man_q[3]);
    rnd    = {1'b0, s2_man_q[MW-1:3]} + RW'(rnd_up);
    e3     = s2_exp_q + EW1'(rnd[MAN_W+1]) + EW1'(s2_exp_q == '0 && rnd[MAN_W]);
    inv3   = 1'b0;
    ovf3   = 1'b0;
    inx3   = |s2_man_q[2:0];
    res3   = {s2_sign_q, e3[EXP_W-1:0], rnd[MAN_W+1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
    if (s2_spec_q) begin
      res3 = s2_spec_res_q;
      inv3 = s2_inv_q;
      inx3 = 1'b0;
    end else if (e3 >= {1'b0, EXP_ONES}) begin
      res3 = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf3 = 1'b1;
      inx3 = 1'b1;
    end
  end

  logic         inv_q, ovf_q, inx_q;
  logic [W-1:0] res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q <= 1'b0; res_q <= '0; inv_q <= 1'b0; ovf_q <= 1'b0; inx_q <= 1'b0;
    end else if (adv3) begin
      v3_q  <= v2_q;
      res_q <= res3;
      inv_q <= inv3;
      ovf_q <= ovf3;
      inx_q <= inx3;
    end
  end

  assign bus.out_valid     = v3_q;
  assign bus.result        = res_q;
  assign bus.flag_invalid  = inv_q;
  assign bus.flag_overflow = ovf_q;
  assign bus.flag_inexact  = inx_q;
endmodule
